// File: rtl/nios2_seq_div_cell_if.sv
// Divide-path bundle between the execute stage (master) and the divider cell (slave).
// The master drives operands and the start request; the slave returns the results and status.
interface nios2_seq_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_div_start;
  logic             E_div_signed;
  logic [WIDTH-1:0] M_div_quot;
  logic [WIDTH-1:0] M_div_rem;
  logic             M_div_done;
  logic             M_div_busy;
  logic             M_div_by_zero;

  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed,
    input  M_div_quot, M_div_rem, M_div_done, M_div_busy, M_div_by_zero
  );

  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed,
    output M_div_quot, M_div_rem, M_div_done, M_div_busy, M_div_by_zero
  );
endinterface

// File: rtl/nios2_seq_div_cell.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per clock.
// Optional macro DIV_ZERO_EARLY_DONE_EN: a zero divisor skips the iteration phase.
module nios2_seq_div_cell #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  nios2_seq_div_cell_if.slave div
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             signed_q;
  logic             sign_q;
  logic             sign_r;
  logic             zero_q;

  logic [WIDTH-1:0] quot_out;
  logic [WIDTH-1:0] rem_out;
  logic             done_out;
  logic             busy_out;
  logic             by_zero_out;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return $unsigned(-v);
  endfunction

  // Magnitude is unsigned WIDTH-bit, so the most negative value maps onto 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && (v < 0)) ? negate(v) : $unsigned(v);
  endfunction

  // Partial remainder never reaches its MSB before the final step, so dropping it is safe.
  always_comb begin
    shifted = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, dsr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      src1_q      <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      signed_q    <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_q      <= 1'b0;
      quot_out    <= '0;
      rem_out     <= '0;
      done_out    <= 1'b0;
      busy_out    <= 1'b0;
      by_zero_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (div.E_div_start) begin
            src1_q   <= div.E_src1;
            dvd      <= div.E_src1;
            dsr      <= div.E_src2;
            signed_q <= div.E_div_signed;
            busy_out <= 1'b1;
            state    <= PREP;
          end
        end

        PREP: begin
          sign_q <= signed_q & (dvd[WIDTH-1] ^ dsr[WIDTH-1]);
          sign_r <= signed_q & dvd[WIDTH-1];
          dvd    <= magnitude(dvd, signed_q);
          dsr    <= magnitude(dsr, signed_q);
          zero_q <= (dsr == '0);
          rem    <= '0;
          count  <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_EARLY_DONE_EN
          state  <= (dsr == '0) ? FIX : ITER;
`else
          state  <= ITER;
`endif
        end

        // Quotient bits are shifted into the dividend register as it empties.
        ITER: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CNT_W'(1);
          end
        end

        FIX: begin
          if (zero_q) begin
            quot_out    <= '1;
            rem_out     <= src1_q;
            by_zero_out <= 1'b1;
          end else begin
            quot_out    <= sign_q ? negate(dvd) : dvd;
            rem_out     <= sign_r ? negate(rem) : rem;
            by_zero_out <= 1'b0;
          end
          state <= DONE;
        end

        DONE: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
      endcase
    end
  end

  assign div.M_div_quot    = quot_out;
  assign div.M_div_rem     = rem_out;
  assign div.M_div_done    = done_out;
  assign div.M_div_busy    = busy_out;
  assign div.M_div_by_zero = by_zero_out;
endmodule

// File: tb/tb_nios2_seq_div_cell.sv
// Self-checking bench for nios2_seq_div_cell: directed, random, handshake and reset scenarios.
// Expected results come from a plain-arithmetic division model.
module tb_nios2_seq_div_cell;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 3;
`ifdef DIV_ZERO_EARLY_DONE_EN
  localparam bit EARLY_ZERO = 1'b1;
`else
  localparam bit EARLY_ZERO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  nios2_seq_div_cell_if #(.WIDTH(WIDTH)) div ();

  nios2_seq_div_cell #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
  } vec_t;

  // Truncating division; SV '/' and '%' on longint already follow those rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r, output logic bz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q  = '1;
      r  = a;
      bz = 1'b1;
    end else begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      bz = 1'b0;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    div.E_src1       = a;
    div.E_src2       = b;
    div.E_div_signed = sg;
    div.E_div_start  = 1'b1;
    @(posedge clk);
    #1;
    div.E_div_start  = 1'b0;
    div.E_src1       = $urandom;
    div.E_src2       = $urandom;
    div.E_div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (div.M_div_done) begin
        lat = i;
        break;
      end
      if (!div.M_div_busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    if ({div.M_div_quot, div.M_div_rem} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got q=%h r=%h want 0", div.M_div_quot, div.M_div_rem);
    end
    checks++;
    if ({div.M_div_done, div.M_div_busy, div.M_div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got done/busy/bz=%b%b%b want 000",
               div.M_div_done, div.M_div_busy, div.M_div_by_zero);
    end
    checks++;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if ({div.M_div_done, div.M_div_busy, div.M_div_quot} !== 34'd0) begin
      errors++;
      $display("FAIL idle_after_reset got done=%b busy=%b q=%h want 0",
               div.M_div_done, div.M_div_busy, div.M_div_quot);
    end
    checks++;
  endtask

  task automatic test_directed;
    vec_t        vecs[6];
    int          lat;
    logic        busy_ok;
    int          want_lat;
    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
    vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0};
    vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0};
    vecs[4] = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  1'b1};
    vecs[5] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
    for (int i = 0; i < 6; i++) begin
      want_lat = (EARLY_ZERO && vecs[i].b == 32'd0) ? 3 : LAT;
      issue(vecs[i].a, vecs[i].b, vecs[i].sg);
      wait_done(lat, busy_ok);
      if (lat !== want_lat) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, want_lat);
      end
      checks++;
      if (busy_ok !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_busy got low during operation want high", i);
      end
      checks++;
      if ({div.M_div_quot, div.M_div_rem, div.M_div_by_zero} !== {vecs[i].q, vecs[i].r, vecs[i].bz}) begin
        errors++;
        $display("FAIL dir%0d_result got q=%h r=%h bz=%b want q=%h r=%h bz=%b", i,
                 div.M_div_quot, div.M_div_rem, div.M_div_by_zero, vecs[i].q, vecs[i].r, vecs[i].bz);
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      if ({div.M_div_done, div.M_div_busy, div.M_div_quot, div.M_div_rem} !== {2'b00, vecs[i].q, vecs[i].r}) begin
        errors++;
        $display("FAIL dir%0d_hold got done=%b busy=%b q=%h r=%h want done=0 busy=0 q=%h r=%h", i,
                 div.M_div_done, div.M_div_busy, div.M_div_quot, div.M_div_rem, vecs[i].q, vecs[i].r);
      end
      checks++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int          lat;
    logic        busy_ok;
    int          want_lat;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'($urandom_range(0, 3));
        1:       b = 32'($urandom_range(1, 255));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom;
      endcase
      model(a, b, sg, q, r, bz);
      want_lat = (EARLY_ZERO && b == 32'd0) ? 3 : LAT;
      issue(a, b, sg);
      wait_done(lat, busy_ok);
      if (lat !== want_lat) begin
        errors++;
        $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, want_lat);
      end
      checks++;
      if ({div.M_div_quot, div.M_div_rem, div.M_div_by_zero} !== {q, r, bz}) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h s=%b got q=%h r=%h bz=%b want q=%h r=%h bz=%b", i,
                 a, b, sg, div.M_div_quot, div.M_div_rem, div.M_div_by_zero, q, r, bz);
      end
      checks++;
    end
  endtask

  task automatic test_busy_start;
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int          lat;
    logic        busy_ok;
    model(32'd1000, 32'd33, 1'b0, q, r, bz);
    issue(32'd1000, 32'd33, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div.E_src1       = 32'd999999;
    div.E_src2       = 32'd3;
    div.E_div_signed = 1'b0;
    div.E_div_start  = 1'b1;
    @(posedge clk);
    #1;
    div.E_div_start  = 1'b0;
    wait_done(lat, busy_ok);
    if (lat !== LAT - 10) begin
      errors++;
      $display("FAIL busy_start_latency got %0d want %0d", lat, LAT - 10);
    end
    checks++;
    if ({div.M_div_quot, div.M_div_rem} !== {q, r}) begin
      errors++;
      $display("FAIL busy_start_result got q=%h r=%h want q=%h r=%h", div.M_div_quot, div.M_div_rem, q, r);
    end
    checks++;
  endtask

  // Called while the done pulse of the previous operation is visible.
  task automatic test_back_to_back;
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int          lat;
    logic        busy_ok;
    int          extra;
    model(32'hFFFFF000, 32'd10, 1'b1, q, r, bz);
    issue(32'hFFFFF000, 32'd10, 1'b1);
    if (div.M_div_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", div.M_div_busy);
    end
    checks++;
    wait_done(lat, busy_ok);
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_latency got %0d want %0d", lat, LAT);
    end
    checks++;
    if ({div.M_div_quot, div.M_div_rem} !== {q, r}) begin
      errors++;
      $display("FAIL b2b_result got q=%h r=%h want q=%h r=%h", div.M_div_quot, div.M_div_rem, q, r);
    end
    checks++;
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (div.M_div_done) extra++;
    end
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_extra_done got %0d extra pulses want 0", extra);
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic busy_ok;
    int   extra;
    issue(32'd12345, 32'd17, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    if ({div.M_div_quot, div.M_div_rem} !== 64'd0) begin
      errors++;
      $display("FAIL midreset_data got q=%h r=%h want 0", div.M_div_quot, div.M_div_rem);
    end
    checks++;
    if ({div.M_div_done, div.M_div_busy, div.M_div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_flags got done/busy/bz=%b%b%b want 000",
               div.M_div_done, div.M_div_busy, div.M_div_by_zero);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (div.M_div_done || div.M_div_busy) extra++;
    end
    if (extra !== 0) begin
      errors++;
      $display("FAIL midreset_abandon got %0d active cycles want 0", extra);
    end
    checks++;
    issue(32'd50, 32'd5, 1'b0);
    wait_done(lat, busy_ok);
    if ({div.M_div_quot, div.M_div_rem, div.M_div_by_zero} !== {32'd10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_result got q=%h r=%h bz=%b want q=a r=0 bz=0",
               div.M_div_quot, div.M_div_rem, div.M_div_by_zero);
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL after_reset_latency got %0d want %0d", lat, LAT);
    end
    checks++;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    div.E_src1       = '0;
    div.E_src2       = '0;
    div.E_div_start  = 1'b0;
    div.E_div_signed = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    test_directed;
    test_random;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios2_seq_div_cell.md
Name: nios2_seq_div_cell

Overview:
- Iterative restoring divider for the CPU's divide path. It is the inverse-operation companion to the multiplier cell in the same execute/memory pipeline.
- Accepts E_src1 (dividend) and E_src2 (divisor) on a start pulse, iterates one quotient bit per clock, and returns quotient, remainder and a one-cycle done pulse.
- Supports signed (div) and unsigned (divu) operation.

Parameters:
- WIDTH, 32, operand/result width in bits (legal: 8..32, even).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_src1  in  WIDTH  dividend, sampled when E_div_start accepted.
- E_src2  in  WIDTH  divisor, sampled when E_div_start accepted.
- E_div_start  in  1  start request; accepted only in IDLE.
- E_div_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- M_div_quot  out  WIDTH  registered quotient, held until next completion.
- M_div_rem  out  WIDTH  registered remainder, held until next completion.
- M_div_done  out  1  one-cycle pulse; M_div_quot/M_div_rem valid.
- M_div_busy  out  1  high in every state except IDLE.
- M_div_by_zero  out  1  registered with done; 1 if divisor was 0.

Behaviour:
- Reset (async, active-high): state IDLE; M_div_quot=0, M_div_rem=0, M_div_done=0, M_div_busy=0, M_div_by_zero=0; counter and working registers 0.
- Reset mid-operation: operation abandoned immediately; no done pulse after release.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: on edge with E_div_start=1, latch operands and E_div_signed, go PREP. Otherwise stay.
- PREP (1 cycle):
  - Signed mode: record sign_q = s1[MSB]^s2[MSB] and sign_r = s1[MSB].
  - Replace each operand by its magnitude; the magnitude is an unsigned WIDTH-bit value, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Flag divisor==0.
  - Load partial remainder=0, count=WIDTH-1; go ITER.
- ITER (exactly WIDTH cycles), per edge:
  - trial = {rem[WIDTH-2:0], dvd[MSB]} - dsr, computed WIDTH+1 bits wide.
  - If no borrow: rem=trial, quotient bit=1; else rem=shifted value, bit=0.
  - dvd shifts left, inserting the quotient bit.
  - When count==0, go FIX; else count decrements.
- FIX (1 cycle), registers outputs:
  - Normal case: quot negated if sign_q, rem negated if sign_r (signed mode only).
  - Divide by zero: quot = all ones, rem = original E_src1 value unchanged, M_div_by_zero=1, sign fix skipped.
- DONE (1 cycle): M_div_done=1; next edge returns to IDLE.
- Latency: start sampled on edge 0; M_div_done high in the cycle after edge WIDTH+3 (35 for WIDTH=32). Back-to-back issue: next start accepted in the cycle after DONE.
- Start handshake:
  - E_div_start while busy (including in DONE) is ignored, not queued.
  - Operand changes after acceptance have no effect.
- Signed overflow (-2^(WIDTH-1) / -1): quot = -2^(WIDTH-1) (0x80000000), rem=0, no flag.
- Arithmetic: truncating division; remainder sign follows dividend; |rem| < |divisor|.
- Outputs hold last result across IDLE; M_div_by_zero cleared only at next completion or reset.

Optional Feature:
- Macro: DIV_ZERO_EARLY_DONE_EN.
- Defined: divisor==0 detected in PREP jumps directly to FIX, skipping ITER. Done appears in the cycle after edge 3 (outputs as above).
- Undefined: divide-by-zero runs the full WIDTH iterations; latency is always WIDTH+3.

Test Plan:
- Unsigned: E_src1=100, E_src2=7, signed=0 -> quot=14, rem=2, done 35 cycles after start, busy high throughout.
- Signed: E_src1=-100 (0xFFFFFF9C), E_src2=7, signed=1 -> quot=-14 (0xFFFFFFF2), rem=-2 (0xFFFFFFFE).
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> quot=0x80000000, rem=0, by_zero=0. Same operands unsigned -> quot=0, rem=0x80000000.
- Divide by zero: 0x12345678 / 0 -> quot=0xFFFFFFFF, rem=0x12345678, by_zero=1. Done at cycle 35, or cycle 3 with DIV_ZERO_EARLY_DONE_EN.
- Start while busy: second start at cycle 10 with different operands -> ignored, single done with first result. Start in the cycle after DONE -> accepted.
- Reset at cycle 20 of an operation -> all outputs 0 immediately, state IDLE, no done. New 50/5 -> quot=10, rem=0.
